// File: rtl/dsi_lane_ctrl_multi.sv
// Multi-lane MIPI D-PHY HS burst sequencer: LP-11 -> LP-01 -> LP-00 -> HS -> LP-11.
// Lanes run in lockstep; each lane's next HS byte comes from a dsi_lane_byte instance.

module dsi_lane_byte #(
  parameter bit MODE = 1'b0
) (
  input  logic       sync_i,
  input  logic       act_i,
  input  logic       trail_i,
  input  logic       trail_ld_i,
  input  logic [7:0] inp_i,
  input  logic [7:0] cur_i,
  output logic [7:0] nxt_o
);
  always_comb begin
    nxt_o = 8'h00;
    if (sync_i)       nxt_o = 8'hB8;
    else if (act_i)   nxt_o = MODE ? 8'h55 : inp_i;
    // Trail level is latched on entry from the last transmitted byte, then held.
    else if (trail_i) nxt_o = MODE ? 8'h00 : (trail_ld_i ? {8{~cur_i[7]}} : cur_i);
  end
endmodule

module dsi_lane_ctrl_multi #(
  parameter int LANES      = 4,
  parameter bit MODE       = 1'b0,
  parameter int CNT_W      = 8,
  parameter int T_LPX      = 100,
  parameter int T_HS_PREP  = 50,
  parameter int T_HS_ZERO  = 100,
  parameter int T_HS_TRAIL = 60,
  parameter int T_HS_EXIT  = 100
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               start_rqst,
  input  logic               fin_rqst,
  input  logic [8*LANES-1:0] inp_data,
  output logic               data_rqst,
  output logic [8*LANES-1:0] hs_data,
  output logic               hs_en,
  output logic               lp_oe,
  output logic [LANES-1:0]   LP_p_output,
  output logic [LANES-1:0]   LP_n_output,
  output logic               active
);
  typedef enum logic [2:0] {
    IDLE, HS_RQST, HS_PREP, HS_ZERO, HS_SYNC, HS_ACTIVE, HS_TRAIL, HS_EXIT
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LANES-1:0][7:0]   hs_q, hs_d;
  logic                    hs_en_q, hs_en_d, lp_oe_q, lp_oe_d;
  logic                    lp_p_q, lp_p_d, lp_n_q, lp_n_d, active_q, active_d;
  logic                    nx_sync, nx_act, nx_trail, trail_ld, cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
    case (state_q)
      IDLE:      if (start_rqst) begin state_d = HS_RQST;  cnt_d = CNT_W'(T_LPX - 1);      end
      HS_RQST:   if (cnt_zero)   begin state_d = HS_PREP;  cnt_d = CNT_W'(T_HS_PREP - 1);  end
      HS_PREP:   if (cnt_zero)   begin state_d = HS_ZERO;  cnt_d = CNT_W'(T_HS_ZERO - 1);  end
      HS_ZERO:   if (cnt_zero)   state_d = MODE ? HS_ACTIVE : HS_SYNC;
      HS_SYNC:   state_d = HS_ACTIVE;
      HS_ACTIVE: if (fin_rqst)   begin state_d = HS_TRAIL; cnt_d = CNT_W'(T_HS_TRAIL - 1); end
      HS_TRAIL:  if (cnt_zero)   begin state_d = HS_EXIT;  cnt_d = CNT_W'(T_HS_EXIT - 1);  end
      HS_EXIT:   if (cnt_zero)   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    hs_en_d  = state_d inside {HS_ZERO, HS_SYNC, HS_ACTIVE, HS_TRAIL};
    lp_oe_d  = ~hs_en_d;
    lp_p_d   = state_d inside {IDLE, HS_EXIT};
    lp_n_d   = state_d inside {IDLE, HS_RQST, HS_EXIT};
    active_d = (state_d != IDLE);
  end

  assign data_rqst = ~MODE & ((state_q == HS_SYNC) | ((state_q == HS_ACTIVE) & ~fin_rqst));
  assign nx_sync   = (state_d == HS_SYNC);
  assign nx_act    = (state_d == HS_ACTIVE);
  assign nx_trail  = (state_d == HS_TRAIL);
  assign trail_ld  = (state_q != HS_TRAIL);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dsi_lane_byte #(.MODE(MODE)) u_lane (
      .sync_i     (nx_sync),
      .act_i      (nx_act),
      .trail_i    (nx_trail),
      .trail_ld_i (trail_ld),
      .inp_i      (inp_data[8*g +: 8]),
      .cur_i      (hs_q[g]),
      .nxt_o      (hs_d[g])
    );
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hs_q     <= '0;
      hs_en_q  <= 1'b0;
      lp_oe_q  <= 1'b1;
      lp_p_q   <= 1'b1;
      lp_n_q   <= 1'b1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hs_q     <= hs_d;
      hs_en_q  <= hs_en_d;
      lp_oe_q  <= lp_oe_d;
      lp_p_q   <= lp_p_d;
      lp_n_q   <= lp_n_d;
      active_q <= active_d;
    end
  end

  assign hs_data     = hs_q;
  assign hs_en       = hs_en_q;
  assign lp_oe       = lp_oe_q;
  assign LP_p_output = {LANES{lp_p_q}};
  assign LP_n_output = {LANES{lp_n_q}};
  assign active      = active_q;
endmodule

// File: tb/tb_dsi_lane_ctrl_multi.sv
// Directed bench: 4-lane data instance and 1-lane clock-lane instance with short timings.
module tb_dsi_lane_ctrl_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        s0 = 1'b0, f0 = 1'b0, s1 = 1'b0, f1 = 1'b0;
  logic [31:0] d0 = '0;
  logic [7:0]  d1 = '0;
  logic        dr0, he0, oe0, act0, dr1, he1, oe1, act1;
  logic [31:0] hd0;
  logic [7:0]  hd1;
  logic [3:0]  lpp0, lpn0;
  logic [0:0]  lpp1, lpn1;

  int total = 0, bad = 0, rq_cnt = 0;

  dsi_lane_ctrl_multi #(.LANES(4), .MODE(1'b0), .CNT_W(8), .T_LPX(3), .T_HS_PREP(2),
                        .T_HS_ZERO(4), .T_HS_TRAIL(3), .T_HS_EXIT(2)) dut0 (
    .clk_sys(clk), .rst_n(rst_n), .start_rqst(s0), .fin_rqst(f0), .inp_data(d0),
    .data_rqst(dr0), .hs_data(hd0), .hs_en(he0), .lp_oe(oe0),
    .LP_p_output(lpp0), .LP_n_output(lpn0), .active(act0));

  dsi_lane_ctrl_multi #(.LANES(1), .MODE(1'b1), .CNT_W(8), .T_LPX(3), .T_HS_PREP(2),
                        .T_HS_ZERO(4), .T_HS_TRAIL(3), .T_HS_EXIT(2)) dut1 (
    .clk_sys(clk), .rst_n(rst_n), .start_rqst(s1), .fin_rqst(f1), .inp_data(d1),
    .data_rqst(dr1), .hs_data(hd1), .hs_en(he1), .lp_oe(oe1),
    .LP_p_output(lpp1), .LP_n_output(lpn1), .active(act1));

  // {active, lp_oe, hs_en, LP_p, LP_n}
  wire [10:0] st0 = {act0, oe0, he0, lpp0, lpn0};
  wire [4:0]  st1 = {act1, oe1, he1, lpp1, lpn1};
  localparam logic [10:0] S0_IDLE = {3'b010, 4'hF, 4'hF}, S0_RQST = {3'b110, 4'h0, 4'hF},
                          S0_PREP = {3'b110, 4'h0, 4'h0}, S0_HS   = {3'b101, 4'h0, 4'h0},
                          S0_EXIT = {3'b110, 4'hF, 4'hF};
  localparam logic [4:0]  S1_IDLE = 5'b01011, S1_RQST = 5'b11001, S1_PREP = 5'b11000,
                          S1_HS   = 5'b10100, S1_EXIT = 5'b11011;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step(); #1;
    total++; if ({st0, hd0, dr0} !== {S0_IDLE, 32'h0, 1'b0}) begin bad++;
      $display("FAIL reset0: got st=%h hs=%h rq=%b want st=%h hs=0 rq=0", st0, hd0, dr0, S0_IDLE); end
    total++; if ({st1, hd1, dr1} !== {S1_IDLE, 8'h0, 1'b0}) begin bad++;
      $display("FAIL reset1: got st=%h hs=%h rq=%b want st=%h hs=0 rq=0", st1, hd1, dr1, S1_IDLE); end
    rst_n = 1'b1;
    step(); #1;
    total++; if (st0 !== S0_IDLE) begin bad++;
      $display("FAIL idle_after_reset: got %h want %h", st0, S0_IDLE); end
  endtask

  // From IDLE through SYNC on dut0; returns at the first HS_ACTIVE cycle with w0 captured.
  task automatic test_preamble(input logic [31:0] w0);
    s0 = 1'b1; step(); s0 = 1'b0;
    for (int i = 0; i < 3; i++) begin #1;
      total++; if (st0 !== S0_RQST) begin bad++; $display("FAIL lp01[%0d]: got %h want %h", i, st0, S0_RQST); end
      step(); end
    for (int i = 0; i < 2; i++) begin #1;
      total++; if (st0 !== S0_PREP) begin bad++; $display("FAIL lp00[%0d]: got %h want %h", i, st0, S0_PREP); end
      step(); end
    for (int i = 0; i < 4; i++) begin #1;
      total++; if ({st0, hd0} !== {S0_HS, 32'h0}) begin bad++;
        $display("FAIL hszero[%0d]: got st=%h hs=%h want st=%h hs=0", i, st0, hd0, S0_HS); end
      step(); end
    d0 = w0; #1;
    total++; if ({st0, hd0, dr0} !== {S0_HS, 32'hB8B8B8B8, 1'b1}) begin bad++;
      $display("FAIL sync: got st=%h hs=%h rq=%b want st=%h hs=b8b8b8b8 rq=1", st0, hd0, dr0, S0_HS); end
    if (dr0) rq_cnt++;
    step();
  endtask

  task automatic test_payload();
    logic [31:0] w [3];
    w[0] = 32'h11223344; w[1] = 32'h55667788; w[2] = 32'h99AABBCC;
    rq_cnt = 0;
    test_preamble(w[0]);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) d0 = w[i+1]; else begin d0 = 32'hDEADBEEF; f0 = 1'b1; end
      #1;
      total++; if ({hd0, dr0} !== {w[i], (i < 2)}) begin bad++;
        $display("FAIL payload[%0d]: got hs=%h rq=%b want hs=%h rq=%b", i, hd0, dr0, w[i], (i < 2)); end
      if (dr0) rq_cnt++;
      step();
    end
    f0 = 1'b0;
    for (int i = 0; i < 3; i++) begin #1;
      total++; if ({st0, hd0} !== {S0_HS, 32'h00000000}) begin bad++;
        $display("FAIL trail[%0d]: got st=%h hs=%h want st=%h hs=0", i, st0, hd0, S0_HS); end
      if (dr0) rq_cnt++;
      step(); end
    #1;
    total++; if (st0 !== S0_EXIT) begin bad++; $display("FAIL exit0: got %h want %h", st0, S0_EXIT); end
    step();
    s0 = 1'b1; #1;   // start coincident with EXIT->IDLE must be ignored
    total++; if (st0 !== S0_EXIT) begin bad++; $display("FAIL exit1: got %h want %h", st0, S0_EXIT); end
    step(); s0 = 1'b0; #1;
    total++; if (st0 !== S0_IDLE) begin bad++; $display("FAIL start_at_exit: got %h want %h", st0, S0_IDLE); end
    step(); #1;
    total++; if (st0 !== S0_IDLE) begin bad++; $display("FAIL idle_hold: got %h want %h", st0, S0_IDLE); end
    total++; if (rq_cnt !== 3) begin bad++; $display("FAIL rq_count: got %0d want 3", rq_cnt); end
  endtask

  task automatic test_min_burst();
    f0 = 1'b1;   // held high from IDLE: only the first HS_ACTIVE cycle may act on it
    test_preamble(32'h12F034A5);
    #1;
    total++; if ({st0, hd0, dr0} !== {S0_HS, 32'h12F034A5, 1'b0}) begin bad++;
      $display("FAIL min_byte: got st=%h hs=%h rq=%b want st=%h hs=12f034a5 rq=0", st0, hd0, dr0, S0_HS); end
    step(); f0 = 1'b0;
    for (int i = 0; i < 3; i++) begin #1;
      total++; if ({st0, hd0} !== {S0_HS, 32'hFF00FF00}) begin bad++;
        $display("FAIL min_trail[%0d]: got st=%h hs=%h want st=%h hs=ff00ff00", i, st0, hd0, S0_HS); end
      step(); end
    for (int i = 0; i < 2; i++) begin #1;
      total++; if ({st0, hd0} !== {S0_EXIT, 32'h0}) begin bad++;
        $display("FAIL min_exit[%0d]: got st=%h hs=%h want st=%h hs=0", i, st0, hd0, S0_EXIT); end
      step(); end
    #1;
    total++; if (st0 !== S0_IDLE) begin bad++; $display("FAIL min_idle: got %h want %h", st0, S0_IDLE); end
  endtask

  task automatic test_reset_mid();
    test_preamble(32'hA1B2C3D4);
    d0 = 32'h01020304; step();
    rst_n = 1'b0; step(); rst_n = 1'b1; #1;
    total++; if ({st0, hd0, dr0} !== {S0_IDLE, 32'h0, 1'b0}) begin bad++;
      $display("FAIL mid_reset: got st=%h hs=%h rq=%b want st=%h hs=0 rq=0", st0, hd0, dr0, S0_IDLE); end
    test_preamble(32'h0F0F0F0F);
    f0 = 1'b1; #1;
    total++; if (hd0 !== 32'h0F0F0F0F) begin bad++; $display("FAIL restart_byte: got %h want 0f0f0f0f", hd0); end
    step(); f0 = 1'b0;
    repeat (5) step();
    #1;
    total++; if (st0 !== S0_IDLE) begin bad++; $display("FAIL restart_idle: got %h want %h", st0, S0_IDLE); end
  endtask

  task automatic test_clock_mode();
    d1 = 8'hA5; s1 = 1'b1; step(); s1 = 1'b0;
    for (int i = 0; i < 3; i++) begin #1;
      total++; if (st1 !== S1_RQST) begin bad++; $display("FAIL ck_lp01[%0d]: got %h want %h", i, st1, S1_RQST); end
      step(); end
    for (int i = 0; i < 2; i++) begin #1;
      total++; if (st1 !== S1_PREP) begin bad++; $display("FAIL ck_lp00[%0d]: got %h want %h", i, st1, S1_PREP); end
      step(); end
    for (int i = 0; i < 4; i++) begin #1;
      total++; if ({st1, hd1, dr1} !== {S1_HS, 8'h00, 1'b0}) begin bad++;
        $display("FAIL ck_zero[%0d]: got st=%h hs=%h rq=%b want st=%h hs=00 rq=0", i, st1, hd1, dr1, S1_HS); end
      step(); end
    for (int i = 0; i < 3; i++) begin
      f1 = (i == 2); #1;
      total++; if ({st1, hd1, dr1} !== {S1_HS, 8'h55, 1'b0}) begin bad++;
        $display("FAIL ck_active[%0d]: got st=%h hs=%h rq=%b want st=%h hs=55 rq=0", i, st1, hd1, dr1, S1_HS); end
      step(); end
    f1 = 1'b0;
    for (int i = 0; i < 3; i++) begin #1;
      total++; if ({st1, hd1, dr1} !== {S1_HS, 8'h00, 1'b0}) begin bad++;
        $display("FAIL ck_trail[%0d]: got st=%h hs=%h rq=%b want st=%h hs=00 rq=0", i, st1, hd1, dr1, S1_HS); end
      step(); end
    for (int i = 0; i < 2; i++) begin #1;
      total++; if (st1 !== S1_EXIT) begin bad++; $display("FAIL ck_exit[%0d]: got %h want %h", i, st1, S1_EXIT); end
      step(); end
    #1;
    total++; if (st1 !== S1_IDLE) begin bad++; $display("FAIL ck_idle: got %h want %h", st1, S1_IDLE); end
  endtask

  initial begin
    test_reset();
    test_payload();
    test_min_burst();
    test_reset_mid();
    test_clock_mode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
